// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the store buffer between the MEM stage and dm_4k.
package store_buffer_pkg;
    localparam int SB_DEPTH = 4;
    localparam int SB_PTR_W = $clog2(SB_DEPTH);
    localparam int DM_AW    = 12;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } sb_state_e;
endpackage

// File: rtl/store_buffer_if.sv
// MEM-stage request/stall handshake plus the shared dm port driven by the store buffer.
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int AW = DM_AW
);
    logic          st_valid;
    logic          st_byte;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          flush_req;
    logic          stall;
    logic          flush_done;
    logic          empty;
    logic          dm_we;
    logic          dm_sb;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_din;

    modport master (
        output st_valid, st_byte, st_addr, st_data, ld_valid, ld_addr, flush_req,
        input  stall, flush_done, empty, dm_we, dm_sb, dm_addr, dm_din
    );

    modport slave (
        input  st_valid, st_byte, st_addr, st_data, ld_valid, ld_addr, flush_req,
        output stall, flush_done, empty, dm_we, dm_sb, dm_addr, dm_din
    );
endinterface

// File: rtl/store_buffer_fifo.sv
// Circular store queue: head/tail/count control plus a per-entry word-address match against the load.
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = DM_AW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enq_i,
    input  logic                     byte_i,
    input  logic [AW-1:0]            addr_i,
    input  logic [31:0]              data_i,
    input  logic                     deq_i,
    input  logic [AW-1:0]            ld_addr_i,
    output logic                     head_byte_o,
    output logic [AW-1:0]            head_addr_o,
    output logic [31:0]              head_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [DEPTH-1:0]         match_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          byte_q [DEPTH];
    logic [AW-1:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] off;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        head_d  = deq_i ? head_q + 1'b1 : head_q;
        tail_d  = enq_i ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CW'(enq_i) - CW'(deq_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_i) begin
            byte_q[tail_q] <= byte_i;
            addr_q[tail_q] <= addr_i;
            data_q[tail_q] <= data_i;
        end
    end

    // An entry is live when its distance from head is below count.
    always_comb begin
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = PW'(i) - head_q;
            match_o[i] = ({1'b0, off} < count_q) &&
                         (addr_q[i][AW-1:2] == ld_addr_i[AW-1:2]);
        end
    end

    assign head_byte_o = byte_q[head_q];
    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign count_o     = count_q;
    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
endmodule

// File: rtl/store_buffer.sv
// Store buffer top: dm port arbitration between loads and drains, pipeline stall, RUN/FLUSH control.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = DM_AW
) (
    input  logic         clk,
    input  logic         rst_n,
    store_buffer_if.slave sb
);
    localparam int CW = $clog2(DEPTH) + 1;

    sb_state_e        state_q;
    logic             flush_done_q;
    logic             head_byte;
    logic [AW-1:0]    head_addr;
    logic [31:0]      head_data;
    logic [CW-1:0]    count;
    logic             full, fifo_empty;
    logic [DEPTH-1:0] match;
    logic             hazard, drain, accept, enq, one_left;

    sb_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .enq_i       (enq),
        .byte_i      (sb.st_byte),
        .addr_i      (sb.st_addr),
        .data_i      (sb.st_data),
        .deq_i       (drain),
        .ld_addr_i   (sb.ld_addr),
        .head_byte_o (head_byte),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (fifo_empty),
        .match_o     (match)
    );

    // A clean load owns the dm port; any hazard or flush hands it to the drain.
    assign hazard   = sb.ld_valid & (|match);
    assign drain    = !fifo_empty & ((state_q == ST_FLUSH) | hazard | !sb.ld_valid);
    assign accept   = !full | drain;
    assign enq      = sb.st_valid & accept & (state_q == ST_RUN) & !sb.flush_req;
    assign one_left = (count == CW'(1));

    always_comb begin
        sb.dm_we   = 1'b0;
        sb.dm_sb   = 1'b0;
        sb.dm_addr = '0;
        sb.dm_din  = '0;
        if (drain) begin
            sb.dm_we   = 1'b1;
            sb.dm_sb   = head_byte;
            sb.dm_addr = head_addr;
            sb.dm_din  = head_data;
        end else if (sb.ld_valid & !hazard) begin
            sb.dm_addr = sb.ld_addr;
        end
    end

    assign sb.stall = (sb.st_valid & !accept) | hazard | (state_q == ST_FLUSH) | sb.flush_req;
    assign sb.empty = fifo_empty;
    assign sb.flush_done = flush_done_q;

    // flush_done is raised on the edge that retires the last entry, so it
    // coincides with the final FLUSH cycle (or the cycle after a flush of an empty buffer).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (sb.flush_req) begin
                        if (fifo_empty | (one_left & drain)) flush_done_q <= 1'b1;
                        if (!fifo_empty) state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (one_left & drain) flush_done_q <= 1'b1;
                    if (fifo_empty) state_q <= ST_RUN;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected dm writes are queued at issue and checked by a monitor.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errs = 0;
    bit   allow_dual = 1'b0;

    logic [44:0] expq[$];
    logic [7:0]  mem [0:4095];

    always #5 clk = ~clk;

    store_buffer_if #(.AW(12)) bus ();

    store_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus)
    );

    // Reference little-endian byte memory standing in for dm_4k.
    always @(posedge clk) begin
        if (rst_n && bus.dm_we) begin
            if (bus.dm_sb) begin
                mem[bus.dm_addr] <= bus.dm_din[7:0];
            end else begin
                mem[{bus.dm_addr[11:2], 2'b00}] <= bus.dm_din[7:0];
                mem[{bus.dm_addr[11:2], 2'b01}] <= bus.dm_din[15:8];
                mem[{bus.dm_addr[11:2], 2'b10}] <= bus.dm_din[23:16];
                mem[{bus.dm_addr[11:2], 2'b11}] <= bus.dm_din[31:24];
            end
        end
    end

    always @(negedge clk) begin
        logic [44:0] got, want;
        if (rst_n && bus.dm_we) begin
            got = {bus.dm_sb, bus.dm_addr, bus.dm_din};
            checks++;
            if (expq.size() == 0) begin
                errs++;
                $display("FAIL dm_write unexpected got=%h", got);
            end else begin
                want = expq.pop_front();
                if (got !== want) begin
                    errs++;
                    $display("FAIL dm_write got=%h want=%h", got, want);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && !allow_dual)
            assert (!(bus.st_valid && bus.ld_valid)) else $error("store and load together");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_st(input logic b, input logic [11:0] a, input logic [31:0] d, input bit expect_wr);
        bus.st_valid = 1'b1;
        bus.st_byte  = b;
        bus.st_addr  = a;
        bus.st_data  = d;
        if (expect_wr) expq.push_back({b, a, d});
    endtask

    task automatic idle();
        bus.st_valid = 1'b0;
        bus.st_byte  = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        idle();
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.flush_req = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_stall", bus.stall, 0);
        chk("rst_flush_done", bus.flush_done, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_dm_we", bus.dm_we, 0);
        chk("rst_dm_sb", bus.dm_sb, 0);
        chk("rst_dm_addr", bus.dm_addr, 0);
        chk("rst_dm_din", bus.dm_din, 0);
        at_neg();
        rst_n = 1'b1;
        step();

        // Single sw, retired one cycle after enqueue.
        set_st(1'b0, 12'h010, 32'h11223344, 1'b1);
        at_neg(); chk("sw_stall", bus.stall, 0);
        step();
        idle();
        at_neg();
        chk("sw_pending", bus.empty, 0);
        chk("sw_drain_we", bus.dm_we, 1);
        chk("sw_drain_addr", bus.dm_addr, 12'h010);
        step();
        at_neg(); chk("sw_empty_after", bus.empty, 1);
        step();

        // Fill to DEPTH behind a clean load, overflow stalls, release accepts alongside the first drain.
        allow_dual = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 12'h300;
        for (int k = 0; k < 4; k++) begin
            set_st(1'b0, 12'(12'h040 + 4 * k), 32'(32'hA0 + k), 1'b1);
            at_neg(); chk("fill_stall", bus.stall, 0);
            step();
        end
        set_st(1'b0, 12'h050, 32'hA4, 1'b1);
        at_neg();
        chk("full_stall", bus.stall, 1);
        chk("full_no_drain", bus.dm_we, 0);
        chk("full_ld_addr", bus.dm_addr, 12'h300);
        step();
        bus.ld_valid = 1'b0;
        allow_dual = 1'b0;
        at_neg();
        chk("full_accept_stall", bus.stall, 0);
        chk("full_drain_addr", bus.dm_addr, 12'h040);
        step();
        idle();
        repeat (4) step();
        at_neg(); chk("wrap_empty", bus.empty, 1);
        step();

        // sb to byte lane 3, then lbu of the same word: one hazard cycle.
        set_st(1'b1, 12'h023, 32'h000000AB, 1'b1);
        at_neg(); chk("sb_stall", bus.stall, 0);
        step();
        idle();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 12'h020;
        at_neg();
        chk("haz_stall", bus.stall, 1);
        chk("haz_dm_sb", bus.dm_sb, 1);
        chk("haz_dm_we", bus.dm_we, 1);
        step();
        at_neg();
        chk("haz_release_stall", bus.stall, 0);
        chk("haz_ld_addr", bus.dm_addr, 12'h020);
        chk("haz_ld_we", bus.dm_we, 0);
        chk("haz_ld_byte", mem[12'h023], 8'hAB);
        step();
        bus.ld_valid = 1'b0;

        // Unrelated load defers the drain by one cycle.
        set_st(1'b0, 12'h200, 32'h00000055, 1'b1);
        at_neg();
        step();
        idle();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 12'h100;
        at_neg();
        chk("ld_pass_stall", bus.stall, 0);
        chk("ld_pass_addr", bus.dm_addr, 12'h100);
        chk("ld_pass_we", bus.dm_we, 0);
        step();
        bus.ld_valid = 1'b0;
        at_neg();
        chk("deferred_we", bus.dm_we, 1);
        chk("deferred_addr", bus.dm_addr, 12'h200);
        step();

        // Flush with three queued entries.
        allow_dual = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 12'h300;
        for (int k = 0; k < 3; k++) begin
            set_st(1'b0, 12'(12'h060 + 4 * k), 32'(32'hC0 + k), 1'b1);
            step();
        end
        idle();
        bus.ld_valid = 1'b0;
        allow_dual = 1'b0;
        bus.flush_req = 1'b1;
        at_neg();
        chk("flush_stall_0", bus.stall, 1);
        chk("flush_done_0", bus.flush_done, 0);
        step();
        bus.flush_req = 1'b0;
        for (int k = 1; k < 4; k++) begin
            at_neg();
            chk("flush_stall", bus.stall, 1);
            chk("flush_done", bus.flush_done, (k == 3) ? 32'd1 : 32'd0);
            step();
        end
        at_neg();
        chk("flush_run_stall", bus.stall, 0);
        chk("flush_run_done", bus.flush_done, 0);
        chk("flush_run_empty", bus.empty, 1);
        step();

        // Flush of an empty buffer.
        bus.flush_req = 1'b1;
        at_neg(); chk("eflush_stall", bus.stall, 1);
        step();
        bus.flush_req = 1'b0;
        at_neg();
        chk("eflush_done", bus.flush_done, 1);
        chk("eflush_stall_after", bus.stall, 0);
        step();
        at_neg(); chk("eflush_done_clear", bus.flush_done, 0);
        step();

        // Asynchronous reset with queued stores: they must never reach dm.
        allow_dual = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 12'h300;
        set_st(1'b0, 12'h080, 32'hDEAD0000, 1'b0);
        step();
        set_st(1'b0, 12'h084, 32'hDEAD0001, 1'b0);
        step();
        idle();
        at_neg();
        #2;
        bus.ld_valid = 1'b0;
        allow_dual = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_empty", bus.empty, 1);
        chk("arst_dm_we", bus.dm_we, 0);
        chk("arst_stall", bus.stall, 0);
        repeat (2) @(posedge clk);
        at_neg();
        rst_n = 1'b1;
        repeat (4) step();
        at_neg(); chk("arst_stays_empty", bus.empty, 1);

        chk("scoreboard_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
